// File: rtl/f2i_pkg.sv
// Shared definitions for the float-to-int request scheduler: default sizes,
// converter latency, the response record and a small modular-index helper.
package f2i_pkg;

  localparam int F2I_WID  = 32;
  localparam int F2I_NREQ = 4;
  localparam int F2I_IDW  = $clog2(F2I_NREQ);

  // Registered converter: result appears one cycle after cv_ce.
  localparam int CONV_LAT = 1;

  typedef struct packed {
    logic [F2I_WID-1:0] data;
    logic [F2I_IDW-1:0] id;
    logic               ovf;
  } f2i_rsp_t;

  // Wrap an index in [0, 2n) back into [0, n).
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/f2i_rr_scheduler_if.sv
// Bundle of request, converter and response signals around the scheduler.
// slave  = scheduler side, master = surrounding system (requesters,
// converter, response consumer).
interface f2i_rr_scheduler_if #(
  parameter int NREQ = f2i_pkg::F2I_NREQ,
  parameter int WID  = f2i_pkg::F2I_WID,
  parameter int IDW  = $clog2(NREQ)
);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*WID-1:0] req_data;

  logic                cv_ce;
  logic [WID-1:0]      cv_i;
  logic [WID-1:0]      cv_o;
  logic                cv_ovf;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [WID-1:0]      rsp_data;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_ovf;

  modport slave (
    input  req_valid, req_data, cv_o, cv_ovf, rsp_ready,
    output req_ready, cv_ce, cv_i, rsp_valid, rsp_data, rsp_id, rsp_ovf
  );

  modport master (
    output req_valid, req_data, cv_o, cv_ovf, rsp_ready,
    input  req_ready, cv_ce, cv_i, rsp_valid, rsp_data, rsp_id, rsp_ovf
  );

endinterface

// File: rtl/f2i_rr_scheduler_arb.sv
// Combinational round-robin arbiter: the search starts one past the last
// granted index and returns the first asserted request as a one-hot grant
// plus its binary index. All-zero grant when nothing is requested.
module rr_arbiter_onehot import f2i_pkg::*; #(
  parameter int NREQ = F2I_NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  logic           found;
  logic [IDW-1:0] k_idx;

  // Rotating priority search, nearest-after-pointer wins
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k_idx = '0;
    for (int off = 1; off <= NREQ; off++) begin
      k_idx = IDW'(rr_wrap(int'(ptr) + off, NREQ));
      if (!found && req[k_idx]) begin
        found      = 1'b1;
        gnt[k_idx] = 1'b1;
        idx        = k_idx;
      end
    end
  end

endmodule

// File: rtl/f2i_rr_scheduler.sv
// Round-robin scheduler sharing one registered float-to-int converter among
// NREQ requesters. Two-deep pipeline: S1 tracks the item whose result is in
// the converter register, the response register presents it downstream.
// Optional statistics counters are built when F2I_SCHED_STATS_EN is defined.
module f2i_rr_scheduler import f2i_pkg::*; #(
  parameter int NREQ = F2I_NREQ,
  parameter int WID  = F2I_WID,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  f2i_rr_scheduler_if.slave  bus
`ifdef F2I_SCHED_STATS_EN
  ,
  output logic [31:0]        stat_conv,
  output logic [15:0]        stat_ovf,
  output logic [15:0]        stat_stall
`endif
);

  // Per-requester view of the packed data bus.
  logic [WID-1:0]  req_word [NREQ];

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            any_req;
  logic            adv;
  logic            issue_ok;
  logic            issue;
  logic [WID-1:0]  cv_i_next;

  logic            s1_vld_reg;
  logic [IDW-1:0]  s1_id_reg;
  logic            s1_ovf_reg;
  logic [IDW-1:0]  rr_ptr_reg;
  logic [WID-1:0]  cv_i_reg;

  logic            rsp_valid_reg;
  logic [WID-1:0]  rsp_data_reg;
  logic [IDW-1:0]  rsp_id_reg;
  logic            rsp_ovf_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_word[gi] = bus.req_data[gi*WID +: WID];
      // Only the granted requester sees ready, and only when we can issue.
      assign bus.req_ready[gi] = issue & gnt[gi];
    end
  endgenerate

  rr_arbiter_onehot #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req  (bus.req_valid),
    .ptr  (rr_ptr_reg),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  // The response slot frees when empty or being taken; S1 can accept a new
  // item when empty or when it moves into the response slot this cycle.
  // Holding issue off during reset keeps requests from being consumed.
  always_comb begin
    any_req   = |bus.req_valid;
    adv       = !rsp_valid_reg | bus.rsp_ready;
    issue_ok  = !s1_vld_reg | adv;
    issue     = rst_n & issue_ok & any_req;
    // Converter input parks on the last issued word so it does not toggle.
    cv_i_next = issue ? req_word[gnt_idx] : cv_i_reg;
  end

  assign bus.cv_ce     = issue;
  assign bus.cv_i      = cv_i_next;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_ovf   = rsp_ovf_reg;

  // S1: load on issue (overflow flag is combinational from cv_i now),
  // otherwise empty out when its item moves on to the response slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_reg <= 1'b0;
      s1_id_reg  <= '0;
      s1_ovf_reg <= 1'b0;
    end else if (issue) begin
      s1_vld_reg <= 1'b1;
      s1_id_reg  <= gnt_idx;
      s1_ovf_reg <= bus.cv_ovf;
    end else if (adv) begin
      s1_vld_reg <= 1'b0;
    end
  end

  // Response slot: take S1 together with the converter's registered result;
  // hold everything while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= '0;
      rsp_ovf_reg   <= 1'b0;
    end else if (adv) begin
      rsp_valid_reg <= s1_vld_reg;
      if (s1_vld_reg) begin
        rsp_data_reg <= bus.cv_o;
        rsp_id_reg   <= s1_id_reg;
        rsp_ovf_reg  <= s1_ovf_reg;
      end
    end
  end

  // Round-robin pointer and parked converter input move only on an accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg <= IDW'(NREQ - 1);
      cv_i_reg   <= '0;
    end else if (issue) begin
      rr_ptr_reg <= gnt_idx;
      cv_i_reg   <= cv_i_next;
    end
  end

`ifdef F2I_SCHED_STATS_EN
  logic        handoff;
  logic        stall;
  logic [31:0] stat_conv_next;
  logic [15:0] stat_ovf_next;
  logic [15:0] stat_stall_next;

  // Saturating increments for the event counters
  always_comb begin
    handoff         = rsp_valid_reg & bus.rsp_ready;
    stall           = rsp_valid_reg & !bus.rsp_ready;
    stat_conv_next  = stat_conv;
    stat_ovf_next   = stat_ovf;
    stat_stall_next = stat_stall;
    if (handoff && (stat_conv != '1))
      stat_conv_next = stat_conv + 32'd1;
    if (handoff && rsp_ovf_reg && (stat_ovf != '1))
      stat_ovf_next = stat_ovf + 16'd1;
    if (stall && (stat_stall != '1))
      stat_stall_next = stat_stall + 16'd1;
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_conv  <= '0;
      stat_ovf   <= '0;
      stat_stall <= '0;
    end else begin
      stat_conv  <= stat_conv_next;
      stat_ovf   <= stat_ovf_next;
      stat_stall <= stat_stall_next;
    end
  end
`endif

endmodule

// File: doc/f2i_rr_scheduler.md
Name: f2i_rr_scheduler

Overview:
- Shares one float-to-int converter (registered output, 1-cycle latency, `ce`-gated) between NREQ requesters.
- Round-robin arbitration with valid/ready on each request port. Returns results on a single tagged valid/ready response port.
- Stalls the converter by holding `cv_ce` low under backpressure. Sits between the error-estimate front end and the integer accumulators.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WID, 32, float/int word width; must match the converter
- IDW, $clog2(NREQ), requester tag width

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_data  in  NREQ*WID  packed floats; requester k at [k*WID +: WID]
- cv_ce  out  1  converter clock enable
- cv_i  out  WID  converter input word
- cv_o  in  WID  converter result, valid the cycle after cv_ce
- cv_ovf  in  1  converter overflow flag, combinational from cv_i, valid the same cycle as cv_ce
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_data  out  WID  converted integer (sign-magnitude, as produced by the converter)
- rsp_id  out  IDW  index of the originating requester
- rsp_ovf  out  1  overflow flag for this result

Behaviour:
- **Reset** (rst_n=0 at posedge): rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0, s1_vld=0, rr_ptr=NREQ-1, cv_ce=0. A request presented during reset is not accepted. An in-flight conversion is discarded.
- **Pipeline:** stage S1 holds {s1_vld, s1_id, s1_ovf}; the response register holds {rsp_valid, rsp_data, rsp_id, rsp_ovf}.
- **Advance:** adv = !rsp_valid | rsp_ready.
  - S1 transfers to the response register when s1_vld & adv.
  - rsp_data captures cv_o.
- **Issue:** issue_ok = !s1_vld | adv.
- **Grant:** combinational round-robin. Search starts at (rr_ptr+1) mod NREQ and picks the first asserted req_valid.
  - req_ready[g] = issue_ok & req_valid[g]; all other bits are 0.
- **Issue cycle:**
  - cv_ce=1 and cv_i = req_data[g].
  - Next cycle: s1_vld=1, s1_id=g, s1_ovf = cv_ovf sampled in the issue cycle, rr_ptr=g.
- **No issue but S1 advances:** s1_vld goes to 0.
- **Idle cycles:** cv_ce=0 whenever no request is accepted. cv_i holds its last value (no toggling). The converter output is therefore frozen while S1 is stalled.
- **Latency and throughput:** accept at cycle T gives rsp_valid at T+2. Sustained throughput is 1 result/cycle with rsp_ready=1.
- **Response hold:** while rsp_valid & !rsp_ready, rsp_* are held stable.
  - If S1 is also full, req_ready=0 for all requesters.
  - If S1 is empty, one more request is accepted, making 2 items in flight.
- **Simultaneous events:** rsp_ready=1 with s1_vld=1 and a new grant performs all three moves in one cycle (response out, S1 to response, new issue).
- **rr_ptr** changes only on an accepted issue. A requester holding req_valid high is served at least once every NREQ accepts.
- **Ordering:** responses leave in issue order. No reordering, no drops.

Optional Feature:
- Macro: F2I_SCHED_STATS_EN.
- When defined, add output ports:
  - stat_conv (32b): count of responses handed off (rsp_valid & rsp_ready).
  - stat_ovf (16b): count of handed-off responses with rsp_ovf=1.
  - stat_stall (16b): cycles with rsp_valid & !rsp_ready.
- All three counters saturate at all-ones and clear on reset.
- When undefined, these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package f2i_pkg:
  - F2I_WID=32 and F2I_NREQ=4 defaults.
  - f2i_rsp_t struct {data, id, ovf}.
  - localparam CONV_LAT=1.
- One natural sub-module: rr_arbiter_onehot. Inputs: req vector, rr_ptr. Outputs: one-hot grant and its encoded index.
- The pipeline and response registers stay in the top.

Test Plan:
- **Single request:** reset, then req_valid=4'b0001 with data 0x40490FDB (3.14159) for one beat, rsp_ready=1.
  - req_ready[0] in cycle T, cv_ce=1.
  - rsp_valid at T+2 with rsp_data=3, rsp_id=0, rsp_ovf=0.
- **All requesters continuous:** req_valid=4'b1111 continuously, rsp_ready=1.
  - Grant order 0,1,2,3,0,… one accept per cycle.
  - rsp_id sequence 0,1,2,3,…
- **Backpressure:** rsp_ready=0 for 5 cycles with 3 requests queued.
  - Exactly 2 accepted.
  - cv_ce=0 and rsp_* stable during the stall.
  - On rsp_ready=1, responses drain in order with values unchanged.
- **Overflow:** request 0x4F800000 (2^32) from requester 2.
  - rsp_ovf=1, rsp_id=2, rsp_data=0x7FFFFFFF.
- **Mid-flight reset:** two items in flight, rst_n=0 for one cycle.
  - Next cycle rsp_valid=0, s1_vld=0.
  - The first post-reset grant goes to requester 0.
- **Stats (F2I_SCHED_STATS_EN):** 10 handoffs including 2 overflows and 3 stall cycles.
  - stat_conv=10, stat_ovf=2, stat_stall=3.
